// File: rtl/pipe_delay_reg.sv
// Elastic valid/ready delay line: DEPTH register stages with bubble collapse,
// synchronous flush and a registered occupancy count.
module pipe_delay_reg #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             accept;
  logic             take;

  // A stage may load whenever it is empty or everything downstream of it moves.
  always_comb begin
    rdy = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !valid[i] || rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign accept    = in_valid && in_ready;
  assign take      = valid[DEPTH-1] && out_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  // Flush clears only the valid bits; data registers keep their contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VALUE;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (rdy[0]) begin
        data[0]  <= in_data;
        valid[0] <= accept;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          data[i]  <= data[i-1];
          valid[i] <= valid[i-1];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      level <= '0;
    end else if (accept && !take) begin
      level <= level + LVL_ONE;
    end else if (take && !accept) begin
      level <= level - LVL_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_delay_reg.sv
// Bench for pipe_delay_reg: directed scenarios followed by random traffic,
// every cycle compared against a queue-based transfer model.
module tb_pipe_delay_reg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;

  pipe_delay_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE('0)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level)
  );

  always #5 clock = ~clock;

  // Model: words held in acceptance order with the cycle each was accepted.
  // The head is visible once it is DEPTH cycles old and its predecessor has left.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               a;
  } ent_t;

  ent_t             q[$];
  int               cyc;
  int               last_take;
  logic [WIDTH-1:0] hold;
  logic             hold_known;
  int               compared;
  int               mismatched;

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                      input logic fl, input logic rs);
    logic exp_vis;
    logic exp_ir;
    logic [LW-1:0] exp_lvl;
    logic acc;
    logic tk;
    int vis_at;
    ent_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #4;
    exp_vis = 1'b0;
    if (q.size() > 0) begin
      vis_at  = (q[0].a + DEPTH > last_take + 1) ? q[0].a + DEPTH : last_take + 1;
      exp_vis = (cyc >= vis_at);
    end
    exp_ir  = !fl && ((q.size() < DEPTH) || ordy);
    exp_lvl = LW'(q.size());

    compared++;
    assert (out_valid === exp_vis) else begin
      mismatched++;
      $error("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_vis);
    end
    compared++;
    assert (in_ready === exp_ir) else begin
      mismatched++;
      $error("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir);
    end
    compared++;
    assert (level === exp_lvl) else begin
      mismatched++;
      $error("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level, exp_lvl);
    end
    if (exp_vis) begin
      compared++;
      assert (out_data === q[0].d) else begin
        mismatched++;
        $error("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, q[0].d);
      end
    end else if (hold_known) begin
      compared++;
      assert (out_data === hold) else begin
        mismatched++;
        $error("FAIL out_data_hold cyc=%0d got=%h exp=%h", cyc, out_data, hold);
      end
    end

    acc = v && exp_ir;
    tk  = exp_vis && ordy;
    @(posedge clock);
    if (rs) begin
      q.delete();
      hold       = '0;
      hold_known = 1'b1;
    end else if (fl) begin
      hold_known = exp_vis;
      if (exp_vis) hold = q[0].d;
      q.delete();
    end else begin
      hold_known = 1'b0;
      if (tk) begin
        void'(q.pop_front());
        last_take = cyc;
      end
      if (acc) begin
        e.d = d;
        e.a = cyc;
        q.push_back(e);
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset      = 1'b0;
    cyc        = 0;
    last_take  = -100;
    hold       = '0;
    hold_known = 1'b1;

    // Reset while stages hold words
    step(1, 16'h1111, 0, 0, 0);
    step(1, 16'h2222, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    step(0, 16'h0000, 1, 0, 0);

    // Streaming
    step(1, 16'h1234, 1, 0, 0);
    step(1, 16'h5678, 1, 0, 0);
    step(1, 16'h9ABC, 1, 0, 0);
    repeat (3) step(0, 16'h0000, 1, 0, 0);

    // Backpressure then release with simultaneous take/accept
    step(1, 16'hAAAA, 0, 0, 0);
    step(1, 16'hBBBB, 0, 0, 0);
    step(1, 16'hCCCC, 0, 0, 0);
    step(1, 16'hCCCC, 0, 0, 0);
    step(1, 16'hCCCC, 1, 0, 0);
    repeat (3) step(0, 16'h0000, 1, 0, 0);

    // Bubble collapse
    step(1, 16'h0001, 0, 0, 0);
    repeat (6) step(0, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);

    // Flush with two words held and a word offered
    step(1, 16'h4444, 0, 0, 0);
    step(1, 16'h5555, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 0);
    step(1, 16'hDDDD, 0, 1, 0);
    repeat (4) step(0, 16'h0000, 1, 0, 0);

    // Reset and flush together, then streaming resumes
    step(1, 16'h6666, 0, 0, 0);
    step(1, 16'hEEEE, 1, 1, 1);
    step(1, 16'h7777, 1, 0, 0);
    step(1, 16'h8888, 1, 0, 0);
    repeat (3) step(0, 16'h0000, 1, 0, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    repeat (4) step(0, 16'h0000, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_delay_reg.md
# pipe_delay_reg

Parametrised elastic delay line that carries a WIDTH-bit datapath word through DEPTH register stages with per-stage valid bits and a valid/ready handshake on both sides. It is the general-purpose inter-stage register for the 16-bit processor datapath. It adds the following over a plain clocked latch:
- backpressure
- bubble collapse
- pipeline flush
- occupancy reporting

## Interface
- WIDTH, 16, data word width in bits (legal: ≥1)
- DEPTH, 2, number of register stages = unstalled latency in cycles (legal: ≥1)
- RESET_VALUE, 0, value loaded into every stage data register on reset
- clock  input  1  rising-edge clock; one clock domain
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all held words
- in_data  input  WIDTH  word offered upstream
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts in_data this cycle (combinational)
- out_data  output  WIDTH  data of last stage (DEPTH-1)
- out_valid  output  1  valid bit of last stage
- out_ready  input  1  downstream takes out_data this cycle
- level  output  clog2(DEPTH+1)  registered count of valid stages

## Operation
- Each stage i (0..DEPTH-1) holds `valid[i]` and `data[i]`. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Ready chain:
  - `rdy[DEPTH] = out_ready`
  - `rdy[i] = !valid[i] | rdy[i+1]`
  - `in_ready = rdy[0] & !flush`
  - The chain is purely combinational from out_ready, flush and the valid bits.
- Stage i loads when `rdy[i]` is 1.
  - For i>0: `data[i] <= data[i-1]` and `valid[i] <= valid[i-1]`.
  - Stage 0 takes in_data, with `valid[0] <= in_valid & in_ready`.
- A stage that does not load holds both data and valid.
- Bubble collapse: a word advances into any empty stage even while out_ready=0. With backpressure, up to DEPTH words are stored.
- Accept event: `in_valid & in_ready`. Take event: `out_valid & out_ready`. Words leave in strict acceptance order; none is duplicated or dropped except by flush or reset.
- level:
  - +1 on accept without take
  - −1 on take without accept
  - unchanged on both or neither
  - Always equals the popcount of `valid[]`. It never exceeds DEPTH and never underflows.
- flush=1 at an edge:
  - All `valid[]` are cleared and level is set to 0.
  - Data registers hold their values, so out_data keeps its last value.
  - in_ready is 0 during the flush cycle, so the offered word is not accepted.
  - A take in that cycle still counts as a completed transfer for the downstream side.
- Priority: reset > flush > normal advance.
- Reset:
  - All `valid[]` are cleared.
  - All `data[]` are set to RESET_VALUE.
  - level is set to 0.
  - This applies even mid-stream or during flush.
- Reset values after the reset edge: out_valid=0, out_data=RESET_VALUE, level=0, in_ready=1 (with flush=0).

## Timing
- Latency: a word presented and accepted in cycle n is captured into stage 0 at the end of cycle n. It is visible on out_data/out_valid during cycle n+DEPTH when not stalled.
- Throughput: one word per cycle with out_ready held at 1.
- Same-cycle pass-through on a full line: when all stages are valid and out_ready=1, in_ready=1 in that same cycle. A simultaneous take and accept leaves level unchanged.
- in_ready has no register between out_ready and itself. Upstream must not make in_valid depend on in_ready.
- in_data/in_valid must be stable only around the clock edge. in_valid may drop without a transfer.
- DEPTH=1 degenerates to a single valid/ready register with 1-cycle latency.

## Test plan
All scenarios use WIDTH=16, DEPTH=2, RESET_VALUE=0.
- Reset: assert reset 1 cycle while stages are valid -> next cycle out_valid=0, out_data=0x0000, level=0, in_ready=1.
- Streaming: out_ready=1, present 0x1234, 0x5678, 0x9ABC in cycles 0–2 -> out_valid=1 in cycles 2–4 with those values in order; level=2 in cycles 2–3.
- Backpressure: out_ready=0, present 0xAAAA, 0xBBBB, then 0xCCCC held.
  - Expected: level=2 and in_ready=0 from cycle 2, with out_data=0xAAAA stable.
  - Then raise out_ready in cycle 4: in cycle 4 in_ready=1, 0xAAAA is taken and 0xCCCC accepted, level stays 2.
  - The outputs that follow are 0xBBBB, then 0xCCCC.
- Bubble collapse: out_ready=0, single word 0x0001 in cycle 0 -> out_valid=1, out_data=0x0001 from cycle 2, held indefinitely; level=1.
- Flush: two words held, assert flush with in_valid=1, in_data=0xDDDD.
  - Expected: in_ready=0 that cycle; next cycle out_valid=0, level=0, out_data unchanged.
  - 0xDDDD never appears on the output.
- Priority: assert reset and flush together with in_valid=1 -> reset result only (out_data=0x0000, level=0); then normal streaming resumes with 2-cycle latency.
